// File: rtl/alu_ctrl_muldiv_if.sv
// EX-stage bus between the pipeline and the ALU control / mul-div sequencer.
interface alu_ctrl_muldiv_if #(parameter int DATA_W = 32);
    logic              valid_i;
    logic [2:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [3:0]        ALUCtrl_o;
    logic              stall_o;
    logic [DATA_W-1:0] hilo_o;
    logic              hilo_sel_o;
    logic              div_zero_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
        input  ALUCtrl_o, stall_o, hilo_o, hilo_sel_o, div_zero_o, hi_o, lo_o
    );
    modport slave (
        input  valid_i, ALUOp_i, funct_i, rs_data_i, rt_data_i,
        output ALUCtrl_o, stall_o, hilo_o, hilo_sel_o, div_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// MIPS EX-stage ALU control decode plus an iterative mult/div sequencer
// (shift-add / restoring divide, one bit per cycle) with HI/LO registers.
module alu_ctrl_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_ctrl_muldiv_if.slave  bus
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state;

    logic [2*W-1:0]   prod, prod_nxt, p_fix;
    logic [W-1:0]     b_mag, orig_rs, hi, lo, q_fix, r_fix, a_in, b_in;
    logic [W:0]       mul_sum, div_sh, div_diff;
    logic [CNT_W-1:0] cnt;
    logic             neg_res, neg_rem, dz, div_zero;
    logic             rtype, start, last, op_signed, op_div, a_neg, b_neg, mf_ok;

    assign rtype     = (bus.ALUOp_i == 3'b010);
    assign start     = bus.valid_i && rtype && (bus.funct_i[5:2] == 4'b0110) && (state == IDLE);
    // funct 24..27: bit0 selects unsigned, bit1 selects divide
    assign op_signed = ~bus.funct_i[0];
    assign op_div    = bus.funct_i[1];
    assign a_neg     = op_signed & bus.rs_data_i[W-1];
    assign b_neg     = op_signed & bus.rt_data_i[W-1];
    assign a_in      = a_neg ? -bus.rs_data_i : bus.rs_data_i;
    assign b_in      = b_neg ? -bus.rt_data_i : bus.rt_data_i;
    assign last      = (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        bus.ALUCtrl_o = {(bus.ALUOp_i == 3'd1) || (bus.ALUOp_i == 3'd7), bus.ALUOp_i};
        if (rtype) begin
            case (bus.funct_i)
                6'd32:                                 bus.ALUCtrl_o = 4'b0010;
                6'd34:                                 bus.ALUCtrl_o = 4'b0110;
                6'd36:                                 bus.ALUCtrl_o = 4'b0000;
                6'd37:                                 bus.ALUCtrl_o = 4'b0001;
                6'd42:                                 bus.ALUCtrl_o = 4'b0111;
                6'd3, 6'd7:                            bus.ALUCtrl_o = 4'b1000;
                6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27: bus.ALUCtrl_o = 4'b1111;
                default:                               bus.ALUCtrl_o = 4'b0010;
            endcase
        end
    end

    // prod holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, b_mag} : {(W+1){1'b0}});
        div_sh   = prod[2*W-1:W-1];
        div_diff = div_sh - {1'b0, b_mag};
        if (state == DIV)
            prod_nxt = div_diff[W] ? {div_sh[W-1:0], prod[W-2:0], 1'b0}
                                   : {div_diff[W-1:0], prod[W-2:0], 1'b1};
        else
            prod_nxt = {mul_sum, prod[W-1:1]};
        p_fix = neg_res ? -prod_nxt : prod_nxt;
        q_fix = neg_res ? -prod_nxt[W-1:0] : prod_nxt[W-1:0];
        r_fix = neg_rem ? -prod_nxt[2*W-1:W] : prod_nxt[2*W-1:W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            prod     <= '0;
            b_mag    <= '0;
            orig_rs  <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    prod    <= {{W{1'b0}}, a_in};
                    b_mag   <= b_in;
                    orig_rs <= bus.rs_data_i;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    dz      <= op_div && (bus.rt_data_i == '0);
                    cnt     <= '0;
                    state   <= op_div ? DIV : MUL;
                end
                MUL, DIV: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        if (state == MUL) begin
                            {hi, lo} <= p_fix;
                        end else if (dz) begin
                            hi       <= orig_rs;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mf_ok          = bus.valid_i && rtype && ((state == IDLE) || (state == DONE));
    assign bus.hilo_sel_o = mf_ok && ((bus.funct_i == 6'd16) || (bus.funct_i == 6'd18));
    assign bus.hilo_o     = !bus.hilo_sel_o ? '0 : (bus.funct_i == 6'd16) ? hi : lo;
    assign bus.stall_o    = start || (state == MUL) || (state == DIV);
    assign bus.div_zero_o = div_zero;
    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode sweep, mul/div results via a
// scoreboard queue, stall timing, divide-by-zero, held instruction, reset abort.
module tb_alu_ctrl_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_muldiv_if #(.DATA_W(32)) b32();
    alu_ctrl_muldiv_if #(.DATA_W(8))  b8();

    alu_ctrl_muldiv #(.DATA_W(32), .CNT_W(6)) dut  (.clk_i(clk), .rst_i(rst), .bus(b32));
    alu_ctrl_muldiv #(.DATA_W(8),  .CNT_W(4)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b8));

    typedef struct { logic [31:0] hi; logic [31:0] lo; logic dz; } res_t;
    typedef struct { logic [2:0] op; logic [5:0] f; logic [3:0] e; } dec_t;
    res_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint la, lb;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (f)
            6'd24: begin p = 64'(la * lb); r.hi = p[63:32]; r.lo = p[31:0]; end
            6'd25: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a; r.lo = '1; r.dz = 1'b1;
                end else if (f == 6'd26) begin
                    r.lo = 32'(la / lb); r.hi = 32'(la % lb);
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        res_t e;
        int n;
        sb.push_back(model(f, a, b));
        b32.valid_i = 1'b1; b32.ALUOp_i = 3'b010; b32.funct_i = f;
        b32.rs_data_i = a; b32.rt_data_i = b;
        #1;
        chk({tag, " start_stall"}, 64'(b32.stall_o), 64'd1);
        n = 0;
        while (b32.stall_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " stall_cycles"}, 64'(n), 64'd33);
        e = sb.pop_front();
        chk({tag, " hi"}, 64'(b32.hi_o), 64'(e.hi));
        chk({tag, " lo"}, 64'(b32.lo_o), 64'(e.lo));
        chk({tag, " div_zero_done"}, 64'(b32.div_zero_o), 64'(e.dz));
        @(posedge clk); #1;
        chk({tag, " div_zero_after"}, 64'(b32.div_zero_o), 64'd0);
        b32.funct_i = 6'd18; #1;
        chk({tag, " mflo"}, 64'(b32.hilo_o), 64'(e.lo));
        chk({tag, " mflo_sel"}, 64'(b32.hilo_sel_o), 64'd1);
        chk({tag, " mflo_nostall"}, 64'(b32.stall_o), 64'd0);
        b32.funct_i = 6'd16; #1;
        chk({tag, " mfhi"}, 64'(b32.hilo_o), 64'(e.hi));
        b32.valid_i = 1'b0;
    endtask

    initial begin
        dec_t dtab[$];
        res_t e;
        int n;
        dtab = '{'{3'd2, 6'd32, 4'b0010}, '{3'd2, 6'd34, 4'b0110}, '{3'd2, 6'd36, 4'b0000},
                 '{3'd2, 6'd37, 4'b0001}, '{3'd2, 6'd42, 4'b0111}, '{3'd2, 6'd3,  4'b1000},
                 '{3'd2, 6'd7,  4'b1000}, '{3'd2, 6'd16, 4'b1111}, '{3'd2, 6'd26, 4'b1111},
                 '{3'd2, 6'd5,  4'b0010}, '{3'd1, 6'd32, 4'b1001}, '{3'd0, 6'd0,  4'b0000},
                 '{3'd0, 6'd34, 4'b0000}, '{3'd7, 6'd0,  4'b1111}, '{3'd6, 6'd42, 4'b0110}};

        rst = 1'b1;
        b32.valid_i = 1'b0; b32.ALUOp_i = 3'd0; b32.funct_i = 6'd0;
        b32.rs_data_i = '0; b32.rt_data_i = '0;
        b8.valid_i = 1'b0; b8.ALUOp_i = 3'd0; b8.funct_i = 6'd0;
        b8.rs_data_i = '0; b8.rt_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", 64'(b32.stall_o), 64'd0);
        chk("rst hi", 64'(b32.hi_o), 64'd0);
        chk("rst lo", 64'(b32.lo_o), 64'd0);
        chk("rst div_zero", 64'(b32.div_zero_o), 64'd0);
        chk("rst hilo", 64'(b32.hilo_o), 64'd0);
        rst = 1'b0;

        foreach (dtab[i]) begin
            b32.ALUOp_i = dtab[i].op; b32.funct_i = dtab[i].f; #1;
            chk($sformatf("decode op%0d f%0d", dtab[i].op, dtab[i].f), 64'(b32.ALUCtrl_o), 64'(dtab[i].e));
        end
        chk("decode no_start_when_invalid", 64'(b32.stall_o), 64'd0);
        @(posedge clk); #1;

        run_op(6'd24, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg hi_const", 64'(b32.hi_o), 64'hFFFF_FFFF);
        chk("mult_neg lo_const", 64'(b32.lo_o), 64'hFFFF_FFEB);
        @(posedge clk); #1;
        run_op(6'd27, 32'd100, 32'd7, "divu");
        chk("divu lo_const", 64'(b32.lo_o), 64'd14);
        run_op(6'd26, -32'sd7, 32'd2, "div_neg");
        chk("div_neg lo_const", 64'(b32.lo_o), 64'hFFFF_FFFD);
        chk("div_neg hi_const", 64'(b32.hi_o), 64'hFFFF_FFFF);
        run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        chk("div_minneg lo_const", 64'(b32.lo_o), 64'h8000_0000);
        chk("div_minneg hi_const", 64'(b32.hi_o), 64'd0);
        run_op(6'd26, 32'd5, 32'd0, "div_zero");
        run_op(6'd27, 32'hF000_0001, 32'd0, "divu_zero");
        run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(6'd24, 32'h8000_0000, 32'h8000_0000, "mult_minneg");
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (k[0]) rb = rb >> 20;
            run_op(6'd24 + 6'(k), ra, rb, $sformatf("rand%0d", k));
        end

        // Held multu: exactly one op, then a restart once back in IDLE
        sb.push_back(model(6'd25, 32'hFFFF_FFFF, 32'd2));
        b32.valid_i = 1'b1; b32.ALUOp_i = 3'b010; b32.funct_i = 6'd25;
        b32.rs_data_i = 32'hFFFF_FFFF; b32.rt_data_i = 32'd2;
        #1;
        n = 0;
        for (int c = 0; c < 34; c++) begin
            if (b32.stall_o === 1'b1) n++;
            if (c == 33) begin
                e = sb.pop_front();
                chk("held done_stall", 64'(b32.stall_o), 64'd0);
                chk("held hi", 64'(b32.hi_o), 64'(e.hi));
                chk("held lo", 64'(b32.lo_o), 64'(e.lo));
            end
            @(posedge clk); #1;
        end
        chk("held stall_count", 64'(n), 64'd33);
        chk("held restart", 64'(b32.stall_o), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; b32.valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(6'd27, 32'd1000, 32'd33, "pre_rst");
        @(posedge clk); #1;
        // Reset arriving mid-mult aborts it and clears HI/LO
        b32.valid_i = 1'b1; b32.ALUOp_i = 3'b010; b32.funct_i = 6'd24;
        b32.rs_data_i = 32'h0001_2345; b32.rt_data_i = 32'h0000_0777;
        repeat (5) @(posedge clk);
        #1;
        b32.funct_i = 6'd16; #1;
        chk("busy hilo_sel", 64'(b32.hilo_sel_o), 64'd0);
        chk("busy hilo", 64'(b32.hilo_o), 64'd0);
        chk("busy stall", 64'(b32.stall_o), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; b32.valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort stall", 64'(b32.stall_o), 64'd0);
        chk("abort hi", 64'(b32.hi_o), 64'd0);
        chk("abort lo", 64'(b32.lo_o), 64'd0);
        @(posedge clk); #1;
        chk("abort idle_stall", 64'(b32.stall_o), 64'd0);
        run_op(6'd27, 32'd100, 32'd7, "post_rst");

        // DATA_W=8 instance
        b8.valid_i = 1'b1; b8.ALUOp_i = 3'b010; b8.funct_i = 6'd24;
        b8.rs_data_i = 8'd15; b8.rt_data_i = 8'd15;
        #1;
        n = 0;
        while (b8.stall_o === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk("w8 stall_cycles", 64'(n), 64'd9);
        chk("w8 hi", 64'(b8.hi_o), 64'h00);
        chk("w8 lo", 64'(b8.lo_o), 64'hE1);
        b8.valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Next-generation ALU control for the MIPS datapath, sitting in EX beside the ALU. It performs the combinational funct/ALUOp decode to the 4-bit ALU control code. It adds a parametrised iterative multiply/divide sequencer (mult, multu, div, divu) with HI/LO registers, mfhi/mflo readout and a pipeline stall output.

Parameters:
DATA_W, 32, operand/HI/LO width; the sequencer runs DATA_W iterations
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  EX stage holds a valid instruction
ALUOp_i  in  3  main-control ALU op; 3'b010 = R-type
funct_i  in  6  instruction funct field
rs_data_i  in  DATA_W  operand A / dividend
rt_data_i  in  DATA_W  operand B / divisor
ALUCtrl_o  out  4  ALU control code
stall_o  out  1  freeze PC, IF/ID and ID/EX this cycle
hilo_o  out  DATA_W  HI (mfhi) or LO (mflo), else 0
hilo_sel_o  out  1  1 when EX result must come from hilo_o
div_zero_o  out  1  one-cycle flag: last divide had divisor 0
hi_o  out  DATA_W  HI register
lo_o  out  DATA_W  LO register

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high.
- Decode is combinational and independent of reset and state.
  - When ALUOp_i != 3'b010: ALUCtrl_o = {(ALUOp_i==1 || ALUOp_i==7), ALUOp_i}. funct_i is ignored.
  - When ALUOp_i == 3'b010, by funct: 32 add->0010; 34 sub->0110; 36 and->0000; 37 or->0001; 42 slt->0111; 3 sra and 7 srav->1000; 16/18/24/25/26/27->1111 (ALU idle); any other funct->0010.
- Start condition: valid_i & ALUOp_i==3'b010 & funct in {24 mult, 25 multu, 26 div, 27 divu} & state==IDLE.
- States and transitions:
  - IDLE -> MUL or DIV on start.
  - MUL/DIV -> DONE after DATA_W iterations.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on rst_i.
- Start cycle T:
  - stall_o=1, combinational from the start condition.
  - Operands latched at the end of T. Signed ops latch magnitudes plus a sign-fix flag; unsigned ops latch raw values.
  - Counter cleared.
- Cycles T+1..T+DATA_W: one iteration per cycle, stall_o=1.
  - MUL: shift-add, 2*DATA_W-bit product.
  - DIV: restoring, one quotient bit per cycle.
- End of cycle T+DATA_W: write HI/LO, enter DONE.
  - mult/multu: {HI,LO} = product. Product is negated when operand signs differ (signed op only).
  - div/divu: LO = quotient, HI = remainder. Signed op: quotient negated if signs differ; remainder takes the dividend's sign.
  - Signed most-negative / -1: LO = most-negative value, HI = 0. No trap.
  - Divisor 0, any div: HI = original rs_data, LO = all ones, no sign fixup.
- Cycle T+DATA_W+1 (DONE):
  - stall_o=0, so the pipeline advances past the mul/div at the end of this cycle.
  - No restart, even though valid_i and funct_i are still presented.
  - div_zero_o=1 here only, and only if the finished op was a divide by zero.
- Total stall is DATA_W+1 cycles per mul/div.
- mfhi (16) / mflo (18) with valid_i, in IDLE or DONE:
  - hilo_sel_o=1, hilo_o = HI or LO combinationally, no stall.
  - A mul/div completing in DONE is visible to the immediately following mfhi/mflo.
- In MUL/DIV states:
  - stall_o=1 regardless of inputs.
  - hilo_sel_o=0.
  - Operand inputs are ignored after latching.
- hi_o/lo_o change only at completion or reset.
- Reset, including mid-operation:
  - Abort the operation; state=IDLE.
  - HI=LO=0, counter=0, div_zero_o=0.
  - stall_o follows the start condition in the next cycle.
  - hilo_o=0 unless mfhi/mflo is decoded.

Test Plan:
- Decode sweep: ALUOp=010 with funct 32/34/36/37/42/3 -> ALUCtrl_o 0010/0110/0000/0001/0111/1000; ALUOp=001 -> 1001; ALUOp=000 -> 0000; ALUOp=000 with funct=34 -> 0000 (funct ignored).
- DATA_W=32 mult rs=-3 (0xFFFFFFFD), rt=7 -> stall_o high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; immediately following mflo returns 0xFFFFFFEB with hilo_sel_o=1.
- divu rs=100, rt=7 -> LO=14, HI=2; div rs=-7, rt=2 -> LO=-3, HI=-1; div 0x80000000 by -1 -> LO=0x80000000, HI=0.
- div rs=5, rt=0 -> HI=5, LO=0xFFFFFFFF; div_zero_o high for exactly the DONE cycle.
- Held instruction: valid_i, ALUOp_i and funct_i held at multu for 40 cycles -> exactly one operation runs; stall_o drops at cycle 33, and the op restarts only if still presented in IDLE.
- rst_i asserted at iteration 10 of a mult -> next cycle state IDLE, stall_o=0 (no start presented), HI=LO=0. Repeat at DATA_W=8: mult 15*15 -> HI=0x00, LO=0xE1 after 9 stall cycles.
